// File: rtl/minsoc_startup_arbiter.sv
// Two-master Wishbone arbiter in front of the startup ROM: one owner at a time,
// round-robin on contention, per-transfer timeout that returns err to the owner.
module minsoc_startup_arbiter #(
  parameter int AW      = 5,
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [AW-1:0] m0_adr_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [31:0]   m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [31:0]   m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t        state;
  logic          last_gnt;   // 0 = M0 held it last, 1 = M1
  logic [TW-1:0] cnt;
  logic          err_q;      // timeout err cycle for the current owner

  logic g0, g1, own_cyc, own_stb, tmo_hit;

  always_comb begin
    g0      = (state == GNT0);
    g1      = (state == GNT1);
    own_cyc = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
    own_stb = (g0 & m0_stb_i) | (g1 & m1_stb_i);
    tmo_hit = own_cyc & own_stb & ~s_ack_i & ~err_q & (cnt == TW'(TIMEOUT - 1));
  end

  // Slave side follows the owner; strobe is held off during the err cycle so
  // the aborted transfer is not re-issued to the ROM.
  always_comb begin
    s_cyc_o = own_cyc;
    s_stb_o = own_cyc & own_stb & ~err_q;
    s_adr_o = '0;
    if (g0) s_adr_o = m0_adr_i;
    if (g1) s_adr_o = m1_adr_i;
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Late acks (after cyc drop or in IDLE) fall through to nobody; ack beats err.
  assign m0_ack_o = s_ack_i & g0 & m0_cyc_i;
  assign m1_ack_o = s_ack_i & g1 & m1_cyc_i;
  assign m0_err_o = err_q & ~s_ack_i & g0 & m0_cyc_i;
  assign m1_err_o = err_q & ~s_ack_i & g1 & m1_cyc_i;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      cnt      <= '0;
      err_q    <= 1'b0;
      gnt_o    <= 2'b00;
    end else begin
      err_q <= tmo_hit;
      if (!own_cyc || !own_stb || s_ack_i || err_q || tmo_hit)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
            state    <= GNT0;
            last_gnt <= 1'b0;
            gnt_o    <= 2'b01;
          end else if (m1_cyc_i) begin
            state    <= GNT1;
            last_gnt <= 1'b1;
            gnt_o    <= 2'b10;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            state <= IDLE;
            gnt_o <= 2'b00;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            state <= IDLE;
            gnt_o <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minsoc_startup_arbiter.sv
// Directed bench for minsoc_startup_arbiter with a registered-ack ROM slave model.
module tb_minsoc_startup_arbiter;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic [4:0]  m0_adr_i, m1_adr_i, s_adr_o;
  logic        m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i;
  logic [31:0] m0_dat_o, m1_dat_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  gnt_o;

  logic        slave_on;
  logic [31:0] rom [0:31];
  int          checks = 0;
  int          errors = 0;

  minsoc_startup_arbiter #(.AW(5), .TIMEOUT(16), .TW(8)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 wb_clk = ~wb_clk;

  // ROM slave: ack one cycle after a strobe, never two acks back to back.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      s_ack_i <= 1'b0;
      s_dat_i <= 32'h0;
    end else begin
      s_ack_i <= slave_on & s_cyc_o & s_stb_o & ~s_ack_i;
      if (s_cyc_o && s_stb_o && !s_ack_i) s_dat_i <= rom[s_adr_o];
    end
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_adr_i = '0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_adr_i = '0;
    repeat (n) tick();
  endtask

  initial begin
    logic [31:0] exp3 [0:3];
    int got, errs, first;
    exp3[0] = 32'h18000000; exp3[1] = 32'hA8200000;
    exp3[2] = 32'hA8400000; exp3[3] = 32'hA8600001;
    for (int i = 0; i < 32; i++) rom[i] = 32'h15000000 | i;
    rom[0] = 32'h18000000; rom[1] = 32'hA8200000;
    rom[2] = 32'hA8400000; rom[3] = 32'hA8600001;
    slave_on = 1'b1;
    wb_rst_n = 1'b0;
    idle(3);
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_scyc", 32'(s_cyc_o), 32'h0);
    chk("rst_sstb", 32'(s_stb_o), 32'h0);
    chk("rst_acks", {30'h0, m1_ack_o, m0_ack_o}, 32'h0);
    chk("rst_errs", {30'h0, m1_err_o, m0_err_o}, 32'h0);
    wb_rst_n = 1'b1;

    // 1: single M0 read, grant @+1, ack @+2
    tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 5'd0; #1;
    chk("t1_gnt_c0", 32'(gnt_o), 32'h0);
    tick(); #1;
    chk("t1_gnt_c1", 32'(gnt_o), 32'h1);
    chk("t1_sstb_c1", 32'(s_stb_o), 32'h1);
    chk("t1_ack_c1", 32'(m0_ack_o), 32'h0);
    tick(); #1;
    chk("t1_ack_c2", 32'(m0_ack_o), 32'h1);
    chk("t1_dat_c2", m0_dat_o, 32'h18000000);
    chk("t1_m1_ack", 32'(m1_ack_o), 32'h0);
    chk("t1_errs", {30'h0, m1_err_o, m0_err_o}, 32'h0);
    idle(3);

    // 2: contention after reset -> M0, turnaround, M1, then M0 again
    wb_rst_n = 1'b0; #1; wb_rst_n = 1'b1;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 5'd0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 5'd4;
    tick(); #1;
    chk("t2_gnt_m0", 32'(gnt_o), 32'h1);
    chk("t2_m1_noack_c1", 32'(m1_ack_o), 32'h0);
    tick(); #1;
    chk("t2_m0_ack", 32'(m0_ack_o), 32'h1);
    chk("t2_m1_noack_c2", 32'(m1_ack_o), 32'h0);
    tick(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; #1;
    chk("t2_gnt_hold", 32'(gnt_o), 32'h1);
    chk("t2_scyc_drop", 32'(s_cyc_o), 32'h0);
    tick(); #1;
    chk("t2_gnt_idle", 32'(gnt_o), 32'h0);
    tick(); #1;
    chk("t2_gnt_m1", 32'(gnt_o), 32'h2);
    chk("t2_sadr_m1", 32'(s_adr_o), 32'h4);
    tick(); #1;
    chk("t2_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("t2_m1_dat", m1_dat_o, 32'h15000004);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick(); #1;
    chk("t2_rr_m0", 32'(gnt_o), 32'h1);
    idle(3);

    // 3: M0 burst of four reads, grant held throughout
    tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_adr_i = 5'(i);
      got = 0;
      for (int k = 0; k < 8 && got == 0; k++) begin
        tick(); #1;
        if (m0_ack_o) got = 1;
      end
      chk($sformatf("t3_ack_seen%0d", i), 32'(got), 32'h1);
      chk($sformatf("t3_dat%0d", i), m0_dat_o, exp3[i]);
      chk($sformatf("t3_gnt%0d", i), 32'(gnt_o), 32'h1);
    end
    idle(3);

    // 4: slave silent, M1 times out; err one cycle, 16 cycles after first s_stb
    slave_on = 1'b0;
    tick(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 5'd7;
    errs = 0; first = -1;
    for (int c = 1; c <= 25; c++) begin
      tick(); #1;
      if (m1_err_o) begin
        errs++;
        if (first < 0) begin
          first = c;
          chk("t4_sstb_in_err", 32'(s_stb_o), 32'h0);
          chk("t4_no_ack_in_err", 32'(m1_ack_o), 32'h0);
        end
      end
      if (m0_err_o) errs = errs + 100;
    end
    chk("t4_err_cycle", 32'(first), 32'd17);
    chk("t4_err_count", 32'(errs), 32'd1);
    idle(3);
    slave_on = 1'b1;

    // 5: M0 leaves before its ack; M1 takes over without a stray ack
    tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 5'd1;
    tick(); #1;
    chk("t5_gnt_m0", 32'(gnt_o), 32'h1);
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 5'd2;
    #1;
    chk("t5_m0_late_ack", 32'(m0_ack_o), 32'h0);
    chk("t5_m1_late_ack", 32'(m1_ack_o), 32'h0);
    tick(); #1;
    chk("t5_gnt_idle", 32'(gnt_o), 32'h0);
    chk("t5_m1_noack_idle", 32'(m1_ack_o), 32'h0);
    tick(); #1;
    chk("t5_gnt_m1", 32'(gnt_o), 32'h2);
    chk("t5_m1_noack_gnt", 32'(m1_ack_o), 32'h0);
    tick(); #1;
    chk("t5_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("t5_m1_dat", m1_dat_o, 32'hA8400000);
    idle(3);

    // 6: reset during a pending M1 transfer, M0 wins afterwards
    slave_on = 1'b0;
    tick(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 5'd3;
    tick(); #1;
    chk("t6_gnt_m1", 32'(gnt_o), 32'h2);
    tick();
    wb_rst_n = 1'b0; #1;
    chk("t6_rst_gnt", 32'(gnt_o), 32'h0);
    chk("t6_rst_scyc", 32'(s_cyc_o), 32'h0);
    chk("t6_rst_sstb", 32'(s_stb_o), 32'h0);
    chk("t6_rst_m1", {30'h0, m1_err_o, m1_ack_o}, 32'h0);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 5'd0;
    tick(); wb_rst_n = 1'b1;
    tick(); #1;
    chk("t6_rr_m0", 32'(gnt_o), 32'h1);
    slave_on = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
